// File: rtl/pipe_register_pkg.sv
// pipe_register_pkg: default geometry shared by the elastic pipeline register files
package pipe_register_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
endpackage

// File: rtl/pipe_register_stage.sv
// pipe_register_stage: one valid/data slot of the elastic pipeline
module pipe_register_stage import pipe_register_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);
  logic [WIDTH-1:0] data_d;
  // advance on load, drop valid on flush, capture data only for real beats
  always_comb begin
    valid_d = flush ? 1'b0 : load ? prev_valid : valid_q;
    data_d  = (load && prev_valid && !flush) ? prev_data : data_q;
  end
  // slot state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/pipe_register.sv
// pipe_register: stallable, bubble-collapsing elastic delay line with flush and occupancy count
module pipe_register import pipe_register_pkg::*; #(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0] v_q, v_d, r, pv;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] pd  [DEPTH];
  logic [CW-1:0]    count_d, count_q;
  // ready ripples back from the output so empty slots always advance; each slot is fed by the one before it
  always_comb begin
    r[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) r[i] = !v_q[i] || r[i+1];
    pv[0] = in_valid;
    pd[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      pv[i] = v_q[i-1];
      pd[i] = d_q[i-1];
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_register_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (r[i]),
      .prev_valid (pv[i]),
      .prev_data  (pd[i]),
      .valid_d    (v_d[i]),
      .valid_q    (v_q[i]),
      .data_q     (d_q[i])
    );
  end
  // occupancy of the next-state valid vector, registered alongside the valids
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) count_d = count_d + CW'(v_d[i]);
  end
  // occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end
  assign in_ready  = r[0] && !flush;
  assign out_valid = v_q[DEPTH-1] && !flush;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: scoreboard-based bench for the elastic pipeline register
module tb_pipe_register;
  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data, exp_data;
  logic [2:0] count;
  logic [7:0] sb [$];
  int         pass_n = 0;
  int         total_n = 0;

  pipe_register #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total_n++;
        if (sb.size() == 0) $display("FAIL sb_unexpected: got %h, expected no beat", out_data);
        else begin
          exp_data = sb.pop_front();
          if (out_data !== exp_data) $display("FAIL sb_order: got %h, expected %h", out_data, exp_data);
          else pass_n++;
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total_n += 4;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", out_valid); else pass_n++;
    if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h, expected 00", out_data); else pass_n++;
    if (count !== 3'd0) $display("FAIL rst_count: got %0d, expected 0", count); else pass_n++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, expected 1", in_ready); else pass_n++;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    total_n++;
    if (count !== 3'd0) $display("FAIL rst_release_count: got %0d, expected 0", count); else pass_n++;
  endtask

  task automatic test_stream;
    int lo, hi, n;
    logic ev;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_data  = 8'(c + 1);
      tick;
      ev = (c >= 3) && (c <= 10);
      lo = (c - 3 > 0) ? c - 3 : 0;
      hi = (c < 7) ? c : 7;
      n  = (hi >= lo) ? hi - lo + 1 : 0;
      total_n += 2;
      if (out_valid !== ev) $display("FAIL stream_valid_c%0d: got %b, expected %b", c, out_valid, ev); else pass_n++;
      if (count !== 3'(n)) $display("FAIL stream_count_c%0d: got %0d, expected %0d", c, count, n); else pass_n++;
    end
    in_valid = 1'b0;
    total_n++;
    if (sb.size() != 0) $display("FAIL stream_drain: got %0d left, expected 0", sb.size()); else pass_n++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'hA0 + 8'(c);
      #1;
      total_n++;
      if (in_ready !== 1'b1) $display("FAIL bp_accept_%0d: got %b, expected 1", c, in_ready); else pass_n++;
      tick;
    end
    in_data = 8'hA4;
    #1;
    total_n += 4;
    if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b, expected 0", in_ready); else pass_n++;
    if (count !== 3'd4) $display("FAIL bp_full_count: got %0d, expected 4", count); else pass_n++;
    if (out_valid !== 1'b1) $display("FAIL bp_full_valid: got %b, expected 1", out_valid); else pass_n++;
    if (out_data !== 8'hA0) $display("FAIL bp_full_data: got %h, expected a0", out_data); else pass_n++;
    tick;
    tick;
    total_n += 2;
    if (in_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b, expected 0", in_ready); else pass_n++;
    if (count !== 3'd4) $display("FAIL bp_hold_count: got %0d, expected 4", count); else pass_n++;
    out_ready = 1'b1;
    #1;
    total_n++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b, expected 1", in_ready); else pass_n++;
    tick;
    total_n++;
    if (count !== 3'd4) $display("FAIL bp_a4_count: got %0d, expected 4", count); else pass_n++;
    in_data = 8'hA5;
    tick;
    total_n++;
    if (count !== 3'd4) $display("FAIL bp_a5_count: got %0d, expected 4", count); else pass_n++;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    tick;
    total_n += 2;
    if (sb.size() != 0) $display("FAIL bp_drain: got %0d left, expected 0", sb.size()); else pass_n++;
    if (count !== 3'd0) $display("FAIL bp_empty_count: got %0d, expected 0", count); else pass_n++;
  endtask

  task automatic test_bubble;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    in_valid = 1'b1;
    in_data  = 8'h22;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    total_n += 3;
    if (count !== 3'd2) $display("FAIL bub_count: got %0d, expected 2", count); else pass_n++;
    if (out_valid !== 1'b1) $display("FAIL bub_valid: got %b, expected 1", out_valid); else pass_n++;
    if (out_data !== 8'h11) $display("FAIL bub_data: got %h, expected 11", out_data); else pass_n++;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total_n += 3;
    if (out_valid !== 1'b1) $display("FAIL bub_next_valid: got %b, expected 1", out_valid); else pass_n++;
    if (out_data !== 8'h22) $display("FAIL bub_next_data: got %h, expected 22", out_data); else pass_n++;
    if (count !== 3'd1) $display("FAIL bub_next_count: got %0d, expected 1", count); else pass_n++;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    total_n++;
    if (sb.size() != 0) $display("FAIL bub_drain: got %0d left, expected 0", sb.size()); else pass_n++;
  endtask

  task automatic test_flush;
    tick;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'h31 + 8'(c);
      tick;
    end
    in_valid = 1'b0;
    total_n++;
    if (count !== 3'd3) $display("FAIL fl_pre_count: got %0d, expected 3", count); else pass_n++;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    #1;
    total_n += 2;
    if (in_ready !== 1'b0) $display("FAIL fl_in_ready: got %b, expected 0", in_ready); else pass_n++;
    if (out_valid !== 1'b0) $display("FAIL fl_out_valid: got %b, expected 0", out_valid); else pass_n++;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    total_n++;
    if (count !== 3'd0) $display("FAIL fl_count: got %0d, expected 0", count); else pass_n++;
    for (int k = 0; k < 5; k++) begin
      total_n++;
      if (out_valid !== 1'b0) $display("FAIL fl_quiet_%0d: got %b, expected 0", k, out_valid); else pass_n++;
      tick;
    end
  endtask

  task automatic test_full_throughput;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'h40 + 8'(c);
      tick;
    end
    total_n++;
    if (count !== 3'd4) $display("FAIL ft_full_count: got %0d, expected 4", count); else pass_n++;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data = 8'h50 + 8'(c);
      #1;
      total_n += 3;
      if (in_ready !== 1'b1) $display("FAIL ft_in_ready_%0d: got %b, expected 1", c, in_ready); else pass_n++;
      if (out_valid !== 1'b1) $display("FAIL ft_out_valid_%0d: got %b, expected 1", c, out_valid); else pass_n++;
      tick;
      if (count !== 3'd4) $display("FAIL ft_count_%0d: got %0d, expected 4", c, count); else pass_n++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    tick;
    total_n += 2;
    if (sb.size() != 0) $display("FAIL ft_drain: got %0d left, expected 0", sb.size()); else pass_n++;
    if (count !== 3'd0) $display("FAIL ft_empty_count: got %0d, expected 0", count); else pass_n++;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_data = 8'h61 + 8'(c);
      tick;
    end
    in_valid = 1'b0;
    total_n++;
    if (count !== 3'd3) $display("FAIL mr_pre_count: got %0d, expected 3", count); else pass_n++;
    #1;
    rst_n = 1'b0;
    #1;
    total_n += 4;
    if (out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b, expected 0", out_valid); else pass_n++;
    if (out_data !== 8'h00) $display("FAIL mr_out_data: got %h, expected 00", out_data); else pass_n++;
    if (count !== 3'd0) $display("FAIL mr_count: got %0d, expected 0", count); else pass_n++;
    if (in_ready !== 1'b1) $display("FAIL mr_in_ready: got %b, expected 1", in_ready); else pass_n++;
    sb.delete();
    tick;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    total_n++;
    if (sb.size() != 0) $display("FAIL mr_recover: got %0d left, expected 0", sb.size()); else pass_n++;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_bubble;
    test_flush;
    test_full_throughput;
    test_reset_midstream;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
